bmp_cmd_queue: RTL

Memory-mapped command front-end for the bitmap placement engine. It sits between the CPU data bus and the sprite/font placer. CPU writes of location and control words become queued draw commands; a dispatcher issues them to the placer one at a time and waits for the placer's completion handshake, so software never stalls on a busy placer. Over the single-shot register decode it replaces, it adds a parametrised FIFO, remove/add/font ops, text-cursor auto-advance, overflow detection and a readable status register.

---
 rtl/bmp_cmd_queue.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bmp_cmd_queue.sv
// Command front-end for the bitmap placer: bus register window, command FIFO
// with text-cursor auto-advance, and a one-at-a-time dispatcher.
//
// state   | meaning
// S_IDLE  | no command outstanding; pops the head when queue non-empty and clear_done
// S_ISSUE | one-cycle strobe to the placer with registered index/location
// S_WAIT  | waiting for the placer_done pulse of the issued command
module bmp_cmd_queue #(
   parameter logic [15:0] BASE_ADDR = 16'hC008,
   parameter int XW      = 10,
   parameter int YW      = 9,
   parameter int IDXW    = 5,
   parameter int DEPTH   = 8,
   parameter int ADV_X   = 16,
   parameter int ADV_Y   = 16,
   parameter int X_LIMIT = 640,
   parameter int Y_LIMIT = 480
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            bmp_sel,
   input  logic            bmp_re,
   input  logic [15:0]     addr,
   input  logic [15:0]     databus,
   output logic [15:0]     rdata,
   input  logic            clear_done,
   input  logic            placer_done,
   output logic            add_img,
   output logic            add_fnt,
   output logic            rem_img,
   output logic [IDXW-1:0] cmd_indx,
   output logic [XW-1:0]   xloc,
   output logic [YW-1:0]   yloc,
   output logic            irq_empty
);
   localparam int PW = $clog2(DEPTH);
   localparam int EW = 2 + IDXW + XW + YW;
   localparam logic [4:0]  DEPTH_C = 5'(DEPTH);
   localparam logic [XW:0] ADV_X_C = (XW+1)'(ADV_X);
   localparam logic [YW:0] ADV_Y_C = (YW+1)'(ADV_Y);
   localparam logic [XW:0] X_LIM_C = (XW+1)'(X_LIMIT);
   localparam logic [YW:0] Y_LIM_C = (YW+1)'(Y_LIMIT);
   localparam logic [1:0]  OP_IMG = 2'd0;
   localparam logic [1:0]  OP_FNT = 2'd1;
   localparam logic [1:0]  OP_REM = 2'd2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t          state;
   logic [EW-1:0]   mem [DEPTH];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [4:0]      count;
   logic            ovf;
   logic [XW-1:0]   xreg;
   logic [YW-1:0]   yreg;

   logic            wr_x, wr_y, wr_ctrl, wr_stat, rd_stat;
   logic            full, empty, busy, push, pop, flush;
   logic [1:0]      push_op, head_op;
   logic [XW:0]     x_sum;
   logic [YW:0]     y_sum;
   logic [EW-1:0]   head;
   logic            unused_bits;

   assign wr_x    = bmp_sel && (addr == BASE_ADDR);
   assign wr_y    = bmp_sel && (addr == BASE_ADDR + 16'd1);
   assign wr_ctrl = bmp_sel && (addr == BASE_ADDR + 16'd2);
   assign wr_stat = bmp_sel && (addr == BASE_ADDR + 16'd3);
   assign rd_stat = bmp_re  && (addr == BASE_ADDR + 16'd3);

   assign full  = (count == DEPTH_C);
   assign empty = (count == 5'd0);
   assign busy  = (state != S_IDLE);
   // A full queue rejects the push even if the dispatcher pops in the same cycle.
   assign push  = wr_ctrl && !full;
   assign pop   = (state == S_IDLE) && !empty && clear_done;
   assign flush = wr_stat && databus[0];

   assign push_op = databus[15] ? OP_REM : (databus[0] ? OP_IMG : OP_FNT);
   assign x_sum   = {1'b0, xreg} + ADV_X_C;
   assign y_sum   = {1'b0, yreg} + ADV_Y_C;
   assign head    = mem[rd_ptr];
   assign head_op = head[EW-1 -: 2];

   assign rdata       = rd_stat ? {busy, ovf, full, empty, 7'b0, count} : 16'h0000;
   assign irq_empty   = empty && (state == S_IDLE);
   assign unused_bits = ^databus;

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {push_op, databus[IDXW:1], xreg, yreg};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         xreg   <= '0;
         yreg   <= '0;
      end else begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + 5'd1;
            else if (pop && !push) count <= count - 5'd1;
         end

         if (wr_ctrl && full)               ovf <= 1'b1;
         else if (wr_stat && databus[1])    ovf <= 1'b0;

         if (wr_x) xreg <= databus[XW-1:0];
         if (wr_y) yreg <= databus[YW-1:0];

         // Cursor advance compares the unwrapped sum so a step past the limit wraps.
         if (push && databus[14]) begin
            if (x_sum >= X_LIM_C) begin
               xreg <= '0;
               yreg <= (y_sum >= Y_LIM_C) ? '0 : y_sum[YW-1:0];
            end else begin
               xreg <= x_sum[XW-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         add_img  <= 1'b0;
         add_fnt  <= 1'b0;
         rem_img  <= 1'b0;
         cmd_indx <= '0;
         xloc     <= '0;
         yloc     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  state    <= S_ISSUE;
                  add_img  <= (head_op == OP_IMG);
                  add_fnt  <= (head_op == OP_FNT);
                  rem_img  <= (head_op == OP_REM);
                  cmd_indx <= head[XW+YW +: IDXW];
                  xloc     <= head[YW +: XW];
                  yloc     <= head[YW-1:0];
               end
            end
            S_ISSUE: begin
               state   <= S_WAIT;
               add_img <= 1'b0;
               add_fnt <= 1'b0;
               rem_img <= 1'b0;
            end
            S_WAIT: begin
               if (placer_done) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
